// File: rtl/div_7_pkg.sv
// div_7_pkg: shared types and sizing for the sequential divide-by-7 unit.
// Build option: DIV7_RADIX4_EN selects two restoring steps per CALC cycle.
package div_7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIVISOR = 7;
    localparam int DATA_W  = 16;
    localparam int Q_W     = 14;
    localparam int R_W     = 4;

`ifdef DIV7_RADIX4_EN
    localparam int STEPS     = DATA_W / 2;
    localparam int STEP_BITS = 2;
`else
    localparam int STEPS     = DATA_W;
    localparam int STEP_BITS = 1;
`endif

    localparam int CNT_W = $clog2(STEPS + 1);

endpackage

// File: rtl/div_7_if.sv
// div_7_if: request/result bundle between a controller and div_7.
// master drives start/data; slave returns valid, busy, q, reminder.
interface div_7_if;
    import div_7_pkg::*;

    logic              start;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              busy;
    logic [R_W-1:0]    reminder;
    logic [Q_W-1:0]    q;

    modport master (
        output start,
        output data,
        input  valid,
        input  busy,
        input  reminder,
        input  q
    );

    modport slave (
        input  start,
        input  data,
        output valid,
        output busy,
        output reminder,
        output q
    );

endinterface

// File: rtl/div_7_step.sv
// div_7_step: one combinational restoring step of division by DIVISOR.
// Ports: r_in/bit_in (partial remainder, next dividend bit) -> r_out, q_bit.
module div_7_step
    import div_7_pkg::*;
(
    input  logic [R_W-1:0] r_in,
    input  logic           bit_in,
    output logic [R_W-1:0] r_out,
    output logic           q_bit
);

    logic [R_W-1:0] shifted;

    // r_in is always below DIVISOR, so its MSB is zero and drops off here.
    logic unused_r_msb;
    assign unused_r_msb = r_in[R_W-1];

    assign shifted = {r_in[R_W-2:0], bit_in};
    assign q_bit   = (shifted >= R_W'(DIVISOR));
    assign r_out   = q_bit ? (shifted - R_W'(DIVISOR)) : shifted;

endmodule

// File: rtl/div_7.sv
// div_7: iterative unsigned 16-bit divide-by-7, restoring shift/subtract.
// Ports: clk, rst (async, active-low), bus (div_7_if.slave). Option: DIV7_RADIX4_EN.
module div_7
    import div_7_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    div_7_if.slave   bus
);

    state_t            state;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] quot;
    logic [R_W-1:0]    rem;
    logic [CNT_W-1:0]  cnt;

    logic              valid_q;
    logic              busy_q;
    logic [Q_W-1:0]    q_q;
    logic [R_W-1:0]    rem_q;

    logic [R_W-1:0]       rem_nx;
    logic [STEP_BITS-1:0] qbits;

    logic [R_W-1:0] r0;
    logic           q0;

    div_7_step u_step0 (
        .r_in   (rem),
        .bit_in (dvd[DATA_W-1]),
        .r_out  (r0),
        .q_bit  (q0)
    );

`ifdef DIV7_RADIX4_EN
    logic [R_W-1:0] r1;
    logic           q1;

    // Second step consumes the remainder of the first in the same cycle.
    div_7_step u_step1 (
        .r_in   (r0),
        .bit_in (dvd[DATA_W-2]),
        .r_out  (r1),
        .q_bit  (q1)
    );

    assign rem_nx = r1;
    assign qbits  = {q0, q1};
`else
    assign rem_nx = r0;
    assign qbits  = q0;
`endif

    // Quotient of a 16-bit value by 7 never exceeds 14 bits.
    logic unused_quot_hi;
    assign unused_quot_hi = ^quot[DATA_W-1:Q_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            dvd     <= '0;
            quot    <= '0;
            rem     <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            q_q     <= '0;
            rem_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd    <= bus.data;
                        quot   <= '0;
                        rem    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    dvd  <= {dvd[DATA_W-STEP_BITS-1:0], {STEP_BITS{1'b0}}};
                    quot <= {quot[DATA_W-STEP_BITS-1:0], qbits};
                    rem  <= rem_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b1;
                    q_q     <= quot[Q_W-1:0];
                    rem_q   <= rem;
                    state   <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.q        = q_q;
    assign bus.reminder = rem_q;

endmodule

// File: tb/tb_div_7.sv
// tb_div_7: randomized self-checking bench for div_7 against d/7, d%7.
// Timing expectations follow the DIV7_RADIX4_EN build option.
module tb_div_7;
    import div_7_pkg::*;

`ifdef DIV7_RADIX4_EN
    localparam int LAT    = 9;
    localparam int BUSY_N = 8;
`else
    localparam int LAT    = 17;
    localparam int BUSY_N = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div_7_if bus();

    div_7 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issue one division and check result, latency, busy width, pulse count.
    task automatic run_op(input logic [15:0] d);
        int             vcnt;
        int             bcnt;
        int             vat;
        int             eq;
        int             er;
        logic [Q_W-1:0] gq;
        logic [R_W-1:0] gr;
        eq = int'(d) / DIVISOR;
        er = int'(d) % DIVISOR;
        gq = 'x;
        gr = 'x;
        vcnt = 0;
        bcnt = 0;
        vat = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.data  = 16'($urandom);
        for (int k = 0; k <= LAT + 3; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy) bcnt++;
            if (bus.valid) begin
                vcnt++;
                if (vat < 0) begin
                    vat = k;
                    gq = bus.q;
                    gr = bus.reminder;
                end
            end
        end
        checks++;
        if (gq !== Q_W'(eq)) begin
            errors++;
            $display("FAIL q d=%0d: got %0d expected %0d", d, gq, eq);
        end
        checks++;
        if (gr !== R_W'(er)) begin
            errors++;
            $display("FAIL rem d=%0d: got %0d expected %0d", d, gr, er);
        end
        checks++;
        if (vat !== LAT) begin
            errors++;
            $display("FAIL latency d=%0d: got %0d expected %0d", d, vat, LAT);
        end
        checks++;
        if (bcnt !== BUSY_N) begin
            errors++;
            $display("FAIL busy_len d=%0d: got %0d expected %0d", d, bcnt, BUSY_N);
        end
        checks++;
        if (vcnt !== 1) begin
            errors++;
            $display("FAIL valid_pulses d=%0d: got %0d expected 1", d, vcnt);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.data  = '0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.valid, bus.busy, bus.q, bus.reminder} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b b=%b q=%0d r=%0d expected all 0",
                     bus.valid, bus.busy, bus.q, bus.reminder);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got v=%b b=%b expected 0 0",
                     bus.valid, bus.busy);
        end
    endtask

    task automatic test_zero();
        run_op(16'd0);
    endtask

    task automatic test_sweep();
        for (int i = 0; i <= 700; i++) run_op(16'(i));
    endtask

    task automatic test_boundaries();
        run_op(16'd65535);
        run_op(16'd65534);
        run_op(16'd6);
        run_op(16'd65533);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) run_op(16'($urandom_range(0, 65535)));
    endtask

    task automatic test_start_ignored();
        int             vcnt;
        logic [Q_W-1:0] gq;
        logic [R_W-1:0] gr;
        gq = 'x;
        gr = 'x;
        vcnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = 16'd100;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.data  = 16'd50;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < 2 * LAT + 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                vcnt++;
                gq = bus.q;
                gr = bus.reminder;
            end
        end
        checks++;
        if (vcnt !== 1) begin
            errors++;
            $display("FAIL ignore_pulses: got %0d expected 1", vcnt);
        end
        checks++;
        if (gq !== Q_W'(100 / 7) || gr !== R_W'(100 % 7)) begin
            errors++;
            $display("FAIL ignore_result: got q=%0d r=%0d expected q=14 r=2", gq, gr);
        end
    endtask

    task automatic test_reset_abort();
        int vcnt;
        vcnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = 16'd500;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (BUSY_N / 2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.valid, bus.busy, bus.q, bus.reminder} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got v=%b b=%b q=%0d r=%0d expected all 0",
                     bus.valid, bus.busy, bus.q, bus.reminder);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (bus.valid || bus.busy) vcnt++;
        end
        checks++;
        if (vcnt !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d active cycles expected 0", vcnt);
        end
        run_op(16'd20);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data  = '0;
        test_reset();
        test_zero();
        test_sweep();
        test_boundaries();
        test_random();
        test_start_ignored();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_7.md
Name: div_7

Overview:
- Sequential unsigned divide-by-7 unit. Accepts a 16-bit dividend on a one-cycle `start` pulse.
- Computes quotient and remainder with an iterative shift/subtract loop that processes 1 bit per cycle.
- Returns the result with a one-cycle `valid` pulse. It is a standalone arithmetic slave driven by a controller that polls `busy`.

Parameters:
- DATA_W, 16, dividend width; also the iteration count in the default build.
- Q_W, 14, quotient output width; floor(65535/7)=9362 fits in 14 bits.
- R_W, 4, remainder output width; values 0..6 only, so the MSB is always 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  request pulse; sampled only in IDLE.
- data  in  DATA_W  unsigned dividend; sampled on the edge that accepts start.
- valid  out  1  one-cycle pulse; q and reminder are correct in that cycle.
- busy  out  1  high while a division is in progress.
- reminder  out  R_W  data % 7.
- q  out  Q_W  data / 7.

Behaviour:
- Reset (rst=0, async): state=IDLE; valid=0, busy=0, q=0, reminder=0; all internal registers cleared.
- Reset asserted mid-division aborts it immediately; no valid pulse is produced for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at a rising edge:
  - latch data into a dividend shift register;
  - clear the partial remainder (4 bits) and the quotient register (DATA_W bits);
  - clear the iteration counter;
  - go to CALC; busy=1 from the following cycle.
- IDLE, start=0: stay in IDLE.
- CALC, each cycle performs one restoring step:
  - r' = {r[2:0], dividend MSB}; shift the dividend left by 1.
  - If r' >= 7: r = r' - 7 and shift quotient bit 1 into the quotient LSB. Otherwise r = r' and shift in 0.
  - Increment the counter.
  - After DATA_W steps, go to DONE.
- DONE (exactly one cycle):
  - valid=1, busy=0;
  - q = quotient[Q_W-1:0] (upper 2 bits are provably 0); reminder = r;
  - next state is IDLE unconditionally.
- Latency: start accepted at edge N; valid is high in the cycle following edge N+DATA_W+1, i.e. 17 cycles in the default build.
- busy is high exactly DATA_W cycles; valid is high exactly 1 cycle.
- start while in CALC or DONE is ignored with no effect and no queueing. A start level held high into IDLE is accepted on the first IDLE edge.
- q and reminder update only on entry to DONE and hold their last result until the next DONE or reset.
- data changes after acceptance have no effect.
- Boundaries:
  - data=0 → q=0, r=0.
  - data=65535 → q=9362, r=1.
  - All arithmetic is unsigned; no overflow is possible.

Optional Feature:
- DIV7_RADIX4_EN defined:
  - CALC performs two restoring steps per cycle, chained combinationally; the step count becomes DATA_W/2 = 8.
  - busy is high 8 cycles; valid arrives 9 cycles after the accepting edge.
  - Results and ports are identical to the default build.
- Undefined (default): one step per cycle, as described above.

Decomposition:
- Package div_7_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - DIVISOR=7, DATA_W, Q_W, R_W;
  - STEPS (DATA_W, or DATA_W/2 under DIV7_RADIX4_EN);
  - counter width $clog2(STEPS+1).
- Sub-module div_7_step is a purely combinational single restoring step:
  - inputs: partial remainder (4 bits) and incoming bit;
  - outputs: new remainder and quotient bit.
  - Instantiate it once, or twice chained under DIV7_RADIX4_EN.

Test Plan:
- Reset 5 cycles, release, then start with data=0 → single valid pulse after 17 cycles, q=0, reminder=0; busy high 16 cycles.
- Sweep data=0..700, waiting for busy low before each start → every result matches i/7 and i%7 (e.g. 7→1,0; 13→1,6; 700→100,0); valid returns to 0 between runs.
- data=65535 → q=9362, reminder=1; data=65534 → q=9362, reminder=0.
- Start data=100; at cycle 5 of CALC pulse start with data=50 → only one valid, q=14, reminder=2; the second start is ignored.
- Start data=500; drive rst=0 at CALC cycle 8 → outputs immediately 0, state IDLE, no valid. After release, data=20 → q=2, reminder=6.
- Build with DIV7_RADIX4_EN and repeat the 0..700 sweep → identical results; valid 9 cycles after start, busy high 8 cycles.
